// File: rtl/if_fetch_if.sv
// Instruction-memory request/acknowledge port: if_fetch is the master, the memory is the slave.
// The request stays high with a stable address until the acknowledge arrives.
interface if_fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: walks fetch_pc over the imem port into a DEPTH-entry {pc,inst} FIFO and feeds a registered pair to decode.
// Ack to inst_o in 2 cycles; IF_BYPASS_EN skips the empty FIFO for 1 cycle.
// stall_i holds the output and stops pops; a request is issued only when FIFO space is guaranteed.
module if_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  if_fetch_if.master  imem,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_e        state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   addr_q;
  logic [31:0]   pc_q;
  logic [31:0]   inst_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  entry_t        fifo_q [DEPTH];

  logic ack_req;
  logic pop;
  logic push;
  logic bypass;

  always_comb begin
    ack_req = (state_q == REQ) && imem.imem_ack_i;
    pop     = !stall_i && (count_q != '0);
`ifdef IF_BYPASS_EN
    bypass  = ack_req && !redirect_i && !stall_i && (count_q == '0);
`else
    bypass  = 1'b0;
`endif
    push    = ack_req && !redirect_i && !bypass;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{pc: addr_q, inst: imem.imem_rdata_i};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      pc_q       <= '0;
      inst_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else if (redirect_i) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fetch_pc_q <= redirect_pc_i;
      pc_q       <= '0;
      inst_q     <= '0;
      // A request still in flight must complete before the new target can be issued.
      if (state_q == IDLE || imem.imem_ack_i) begin
        state_q <= REQ;
        addr_q  <= redirect_pc_i;
      end else begin
        state_q <= DROP;
      end
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);

      if (!stall_i) begin
        if (bypass) begin
          pc_q   <= addr_q;
          inst_q <= imem.imem_rdata_i;
        end else if (count_q != '0) begin
          pc_q   <= fifo_q[rd_ptr_q].pc;
          inst_q <= fifo_q[rd_ptr_q].inst;
        end else begin
          pc_q   <= '0;
          inst_q <= '0;
        end
      end

      case (state_q)
        IDLE: begin
          if (count_d < FULL) begin
            state_q <= REQ;
            addr_q  <= fetch_pc_q;
          end
        end
        REQ: begin
          if (imem.imem_ack_i) begin
            fetch_pc_q <= addr_q + 32'd4;
            if (count_d < FULL) addr_q  <= addr_q + 32'd4;
            else                state_q <= IDLE;
          end
        end
        DROP: begin
          if (imem.imem_ack_i) begin
            state_q <= REQ;
            addr_q  <= fetch_pc_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem.imem_req_o  = (state_q == REQ) || (state_q == DROP);
  assign imem.imem_addr_o = addr_q;
  assign pc_o             = pc_q;
  assign inst_o           = inst_q;
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: randomised memory latency, stalls and redirects against a program-order stream scoreboard.
module tb_if_fetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;

  if_fetch_if imem_bus();

  if_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (imem_bus),
    .pc_o          (pc_o),
    .inst_o        (inst_o)
  );

  always #5 clk = ~clk;

  logic        req_w;
  logic [31:0] addr_w;
  logic        ack_w;
  assign req_w  = imem_bus.imem_req_o;
  assign addr_w = imem_bus.imem_addr_o;
  assign ack_w  = imem_bus.imem_ack_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_next;
  int          lat_min, lat_max, wait_cnt;
  bit          hold_en;
  logic [31:0] hold_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic int next_lat();
    return int'($urandom_range(32'(lat_max), 32'(lat_min)));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decode must see consecutive words from the last reset/redirect target, whatever the timing.
  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back({exp_next, mem_word(exp_next)});
      exp_next = exp_next + 32'd4;
    end
  endtask

  task automatic restart_stream(input logic [31:0] pc);
    exp_q.delete();
    exp_next = pc;
    refill();
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
    redirect_i            = 1'b0;
    imem_bus.imem_ack_i   = 1'b0;
    imem_bus.imem_rdata_i = $urandom();
    if (!rst && req_w && !(hold_en && addr_w == hold_addr)) begin
      if (wait_cnt <= 0) begin
        imem_bus.imem_ack_i   = 1'b1;
        imem_bus.imem_rdata_i = mem_word(addr_w);
        wait_cnt              = next_lat();
      end else begin
        wait_cnt = wait_cnt - 1;
      end
    end
    refill();
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    restart_stream(pc);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    restart_stream(RESET_PC);
    wait_cnt = next_lat();
  endtask

  initial begin : monitor
    logic [63:0] model_out;
    logic [63:0] exp;
    logic        prev_req;
    logic [31:0] prev_addr;
    model_out = '0;
    prev_req  = 1'b0;
    prev_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("rst_out", {pc_o, inst_o}, 64'd0);
        check("rst_imem", {31'd0, req_w, addr_w}, 64'd0);
        model_out = '0;
      end else begin
        if (prev_req && !ack_w)
          check("req_hold", {31'd0, req_w, addr_w}, {31'd0, 1'b1, prev_addr});
        if (redirect_i) begin
          check("redirect_bubble", {pc_o, inst_o}, 64'd0);
          model_out = '0;
        end else if (stall_i) begin
          check("stall_hold", {pc_o, inst_o}, model_out);
        end else if (inst_o != 32'd0) begin
          exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hFFFF_FFFF_FFFF_FFFF;
          check("stream", {pc_o, inst_o}, exp);
          model_out = exp;
        end else begin
          check("bubble_pc", {32'd0, pc_o}, 64'd0);
          model_out = '0;
        end
      end
      prev_req  = rst ? 1'b0 : req_w;
      prev_addr = addr_w;
    end
  end

  initial begin : watchdog
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int acks, bubbles;
    bit found;
    logic [31:0] tgt;
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_bus.imem_ack_i = 1'b0; imem_bus.imem_rdata_i = '0;
    lat_min = 0; lat_max = 0; wait_cnt = 0; hold_en = 1'b0; hold_addr = '0;
    exp_next = RESET_PC;

    // Zero-wait memory: first request, ack latency, one fetch per cycle.
    apply_reset(3);
    tick();
    check("first_req", {31'd0, req_w, addr_w}, {31'd0, 1'b1, RESET_PC});
    repeat (LAT) tick();
    check("first_inst", {pc_o, inst_o}, {RESET_PC, mem_word(RESET_PC)});
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("b2b_out", {pc_o, inst_o}, {RESET_PC + 32'(4*i), mem_word(RESET_PC + 32'(4*i))});
      check("b2b_addr", {32'd0, addr_w}, {32'd0, RESET_PC + 32'(4*(LAT+i))});
    end

    // Stall from reset: exactly DEPTH acks, then the request drops.
    stall_i = 1'b1;
    apply_reset(2);
    acks = 0;
    repeat (10) begin
      tick();
      if (req_w && ack_w) acks++;
    end
    check("stall_acks", 64'(acks), 64'(DEPTH));
    check("stall_req_low", {63'd0, req_w}, 64'd0);
    stall_i = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      tick();
      check("stall_release", {pc_o, inst_o}, {RESET_PC + 32'(4*i), mem_word(RESET_PC + 32'(4*i))});
    end

    // Slow memory drains the FIFO.
    lat_min = 3; lat_max = 3; wait_cnt = 3; bubbles = 0;
    repeat (40) begin
      tick();
      if (inst_o == 32'd0) bubbles++;
    end
    check("lat3_bubbles", {63'd0, bubbles > 0}, 64'd1);

    // Redirect over a pending request for 0x20.
    lat_min = 0; lat_max = 0;
    apply_reset(2);
    hold_en = 1'b1; hold_addr = 32'h20; found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (req_w && addr_w == 32'h20) found = 1'b1;
    end
    check("reach_0x20", {63'd0, found}, 64'd1);
    do_redirect(32'h100);
    tick();
    check("redir_out_bubble", {pc_o, inst_o}, 64'd0);
    check("drop_pending", {31'd0, req_w, addr_w}, {31'd0, 1'b1, 32'h20});
    hold_en = 1'b0;
    tick();
    tick();
    check("redir_next_addr", {31'd0, req_w, addr_w}, {31'd0, 1'b1, 32'h100});
    repeat (12) tick();

    // Wrap at the top of the address space.
    tick();
    do_redirect(32'hFFFF_FFFC);
    tick();
    check("wrap_addr0", {31'd0, req_w, addr_w}, {31'd0, 1'b1, 32'hFFFF_FFFC});
    tick();
    check("wrap_addr1", {31'd0, req_w, addr_w}, {31'd0, 1'b1, 32'h0000_0000});
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (inst_o != 32'd0) found = 1'b1;
    end
    check("wrap_out0", {pc_o, inst_o}, {32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
    tick();
    check("wrap_out1", {pc_o, inst_o}, {32'h0000_0000, mem_word(32'h0000_0000)});

    // Reset while a request is pending with three FIFO entries.
    stall_i = 1'b1; hold_en = 1'b1; hold_addr = 32'hC;
    apply_reset(2);
    repeat (4) tick();
    check("pre_rst_pending", {31'd0, req_w, addr_w}, {31'd0, 1'b1, 32'hC});
    rst = 1'b1;
    tick();
    check("mid_rst_out", {pc_o, inst_o}, 64'd0);
    check("mid_rst_imem", {31'd0, req_w, addr_w}, 64'd0);
    rst = 1'b0; hold_en = 1'b0; stall_i = 1'b0;
    restart_stream(RESET_PC);
    wait_cnt = 0;
    tick();
    check("post_rst_req", {31'd0, req_w, addr_w}, {31'd0, 1'b1, RESET_PC});

    // Random stalls, latencies and redirects.
    lat_min = 0; lat_max = 3;
    repeat (1500) begin
      tick();
      stall_i = ($urandom_range(99, 0) < 30);
      if ($urandom_range(99, 0) < 3) begin
        if ($urandom_range(3, 0) == 0) tgt = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(3, 0));
        else                            tgt = $urandom() & 32'h0000_3FFC;
        do_redirect(tgt);
      end
    end
    stall_i = 1'b0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
